writeback_regfile: RTL and testbench

- Stage-5 writeback end of the pipeline register-data path. Retires the instruction in stage 5 and commits its results to a 16 x 16-bit register file.
- Commits the primary result (ALU/load) to the op1 register. Commits the secondary mult/div result to R0.
- Serves stage-2 operand reads for op1, op2 and R0. The stage-2 forwarding logic overrides these reads whenever a younger producer exists.

---
 rtl/cpu_pkg.sv | 54 +++++
 rtl/reg_bank_16x16.sv | 41 ++++
 rtl/writeback_regfile.sv | 92 +++++++++
 tb/tb_writeback_regfile.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline constants and the stage-5 writeback decode, also used by the forwarding unit.
package cpu_pkg;

    localparam logic [3:0] OP_ALU   = 4'b0000;
    localparam logic [3:0] OP_LOAD  = 4'b1000;
    localparam logic [3:0] OP_STORE = 4'b1011;
    localparam logic [3:0] OP_BR0   = 4'b0100;
    localparam logic [3:0] OP_BR1   = 4'b0101;
    localparam logic [3:0] OP_BR2   = 4'b0110;

    localparam logic [3:0] FN_MULT = 4'b0001;
    localparam logic [3:0] FN_DIV  = 4'b0010;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int OP1_HI = 11;
    localparam int OP1_LO = 8;
    localparam int OP2_HI = 7;
    localparam int OP2_LO = 4;
    localparam int FN_HI  = 3;
    localparam int FN_LO  = 0;

    typedef struct packed {
        logic       wr_p;
        logic       wr_s;
        logic [3:0] addr_p;
    } wb_dec_t;

    function automatic logic [3:0] opcode_of(input logic [15:0] ins);
        return ins[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [3:0] op1_of(input logic [15:0] ins);
        return ins[OP1_HI:OP1_LO];
    endfunction

    function automatic logic [3:0] op2_of(input logic [15:0] ins);
        return ins[OP2_HI:OP2_LO];
    endfunction

    function automatic logic [3:0] funct_of(input logic [15:0] ins);
        return ins[FN_HI:FN_LO];
    endfunction

    function automatic wb_dec_t decode(input logic valid, input logic [15:0] ins);
        wb_dec_t d;
        d.wr_p   = valid && (opcode_of(ins) == OP_ALU || opcode_of(ins) == OP_LOAD);
        d.wr_s   = valid && opcode_of(ins) == OP_ALU &&
                   (funct_of(ins) == FN_MULT || funct_of(ins) == FN_DIV);
        d.addr_p = op1_of(ins);
        return d;
    endfunction

endpackage

// File: rtl/reg_bank_16x16.sv
// Register array: primary write port, secondary R0 write port, three async reads, async clear.
module reg_bank_16x16 #(
    parameter int NREGS = 16,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_p,
    input  logic [3:0]    addr_p,
    input  logic [DW-1:0] data_p,
    input  logic          we_s,
    input  logic [DW-1:0] data_s,
    input  logic [3:0]    raddr1,
    input  logic [3:0]    raddr2,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2,
    output logic [DW-1:0] rdata0
);

    logic [DW-1:0] regs [NREGS];
    logic          p_blocked;

    // Secondary R0 write has priority over a primary write to R0.
    assign p_blocked = we_s && (addr_p == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < unsigned'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we_p && !p_blocked) regs[addr_p] <= data_p;
            if (we_s)               regs[0]      <= data_s;
        end
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];
    assign rdata0 = regs[0];

endmodule

// File: rtl/writeback_regfile.sv
// Stage-5 writeback: decode, commit to reg_bank_16x16, retire counter, write flags.
// Optional macro WB_BYPASS_EN: same-cycle write-through on the read ports.
module writeback_regfile
    import cpu_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid5,
    input  logic [15:0]   instructions5,
    input  logic [DW-1:0] mux3Out,
    input  logic [DW-1:0] r0Outs5,
    input  logic [15:0]   instruction2,
    output logic [DW-1:0] r1Data,
    output logic [DW-1:0] r2Data,
    output logic [DW-1:0] r0Data,
    output logic          wbEnP,
    output logic          wbEnS,
    output logic [15:0]   retireCount
);

    wb_dec_t       dec;
    logic          collision;
    logic          wr_p;
    logic [3:0]    raddr1;
    logic [3:0]    raddr2;
    logic [DW-1:0] bank_r1;
    logic [DW-1:0] bank_r2;
    logic [DW-1:0] bank_r0;

    assign dec       = decode(valid5, instructions5);
    assign collision = dec.wr_p && dec.wr_s && (dec.addr_p == '0);
    assign wr_p      = dec.wr_p && !collision;
    assign raddr1    = op1_of(instruction2);
    assign raddr2    = op2_of(instruction2);

    reg_bank_16x16 #(
        .NREGS (NREGS),
        .DW    (DW)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .we_p   (dec.wr_p),
        .addr_p (dec.addr_p),
        .data_p (mux3Out),
        .we_s   (dec.wr_s),
        .data_s (r0Outs5),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (bank_r1),
        .rdata2 (bank_r2),
        .rdata0 (bank_r0)
    );

`ifdef WB_BYPASS_EN
    function automatic logic [DW-1:0] through(input logic [3:0] addr, input logic [DW-1:0] stored,
                                             input logic p, input logic s, input logic in_rst,
                                             input logic [3:0] tgt, input logic [DW-1:0] dp,
                                             input logic [DW-1:0] ds);
        if (in_rst)                  return '0;
        if (s && addr == '0)         return ds;
        if (p && addr == tgt)        return dp;
        return stored;
    endfunction

    // Reset gates the bypass so reads stay at zero while rst is held.
    always_comb begin
        r1Data = through(raddr1, bank_r1, wr_p, dec.wr_s, rst, dec.addr_p, mux3Out, r0Outs5);
        r2Data = through(raddr2, bank_r2, wr_p, dec.wr_s, rst, dec.addr_p, mux3Out, r0Outs5);
        r0Data = through(4'd0,   bank_r0, wr_p, dec.wr_s, rst, dec.addr_p, mux3Out, r0Outs5);
    end
`else
    assign r1Data = bank_r1;
    assign r2Data = bank_r2;
    assign r0Data = bank_r0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbEnP       <= 1'b0;
            wbEnS       <= 1'b0;
            retireCount <= '0;
        end else begin
            wbEnP <= wr_p;
            wbEnS <= dec.wr_s;
            if (valid5) retireCount <= retireCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed plan, random retires, counter wrap.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid5;
    logic [15:0] instructions5;
    logic [15:0] mux3Out;
    logic [15:0] r0Outs5;
    logic [15:0] instruction2;
    logic [15:0] r1Data;
    logic [15:0] r2Data;
    logic [15:0] r0Data;
    logic        wbEnP;
    logic        wbEnS;
    logic [15:0] retireCount;

    writeback_regfile #(
        .NREGS (16),
        .DW    (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid5        (valid5),
        .instructions5 (instructions5),
        .mux3Out       (mux3Out),
        .r0Outs5       (r0Outs5),
        .instruction2  (instruction2),
        .r1Data        (r1Data),
        .r2Data        (r2Data),
        .r0Data        (r0Data),
        .wbEnP         (wbEnP),
        .wbEnS         (wbEnS),
        .retireCount   (retireCount)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: architectural registers, retire count, expected flags.
    logic [15:0] mregs [16];
    logic [15:0] mcnt;
    logic        mp;
    logic        ms;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic writes_primary(input logic v, input logic [15:0] ins);
        return v && (ins[15:12] == 4'h0 || ins[15:12] == 4'h8);
    endfunction

    function automatic logic writes_r0(input logic v, input logic [15:0] ins);
        return v && ins[15:12] == 4'h0 && (ins[3:0] == 4'h1 || ins[3:0] == 4'h2);
    endfunction

    // Value a read port should show before the edge that commits ins.
    function automatic logic [15:0] exp_read(input logic v, input logic [15:0] ins, input logic [15:0] m3,
                                             input logic [15:0] r0o, input logic [3:0] addr);
`ifdef WB_BYPASS_EN
        if (writes_r0(v, ins) && addr == 4'd0) return r0o;
        if (writes_primary(v, ins) && addr == ins[11:8]) return m3;
`endif
        return mregs[addr];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) mregs[i] = 16'h0000;
        mcnt = 16'h0000;
        mp   = 1'b0;
        ms   = 1'b0;
    endtask

    task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] m3,
                        input logic [15:0] r0o, input logic [15:0] ins2);
        valid5        = v;
        instructions5 = ins;
        mux3Out       = m3;
        r0Outs5       = r0o;
        instruction2  = ins2;
        #1;
        chk("pre_r1", r1Data, exp_read(v, ins, m3, r0o, ins2[11:8]));
        chk("pre_r2", r2Data, exp_read(v, ins, m3, r0o, ins2[7:4]));
        chk("pre_r0", r0Data, exp_read(v, ins, m3, r0o, 4'd0));
        @(posedge clk);
        mp = writes_primary(v, ins) && !(writes_r0(v, ins) && ins[11:8] == 4'd0);
        ms = writes_r0(v, ins);
        if (mp) mregs[ins[11:8]] = m3;
        if (ms) mregs[0] = r0o;
        if (v) mcnt = mcnt + 16'd1;
        #1 valid5 = 1'b0;
        #1;
        chk("post_r1", r1Data, mregs[ins2[11:8]]);
        chk("post_r2", r2Data, mregs[ins2[7:4]]);
        chk("post_r0", r0Data, mregs[0]);
        chk("wbEnP", 16'(wbEnP), 16'(mp));
        chk("wbEnS", 16'(wbEnS), 16'(ms));
        chk("retireCount", retireCount, mcnt);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  ops [8];
        logic [3:0]  fn;
        logic [15:0] ins;
        ops = '{4'h0, 4'h0, 4'h8, 4'hB, 4'h4, 4'h5, 4'h6, 4'h3};

        rst = 1'b1;
        valid5 = 1'b0;
        instructions5 = 16'h0000;
        mux3Out = 16'h0000;
        r0Outs5 = 16'h0000;
        instruction2 = 16'h0300;
        clear_model();
        repeat (2) @(posedge clk);
        #2;
        chk("reset_r1", r1Data, 16'h0000);
        chk("reset_r0", r0Data, 16'h0000);
        chk("reset_cnt", retireCount, 16'h0000);
        chk("reset_wbEnP", 16'(wbEnP), 16'h0000);
        rst = 1'b0;
        @(posedge clk);
        #2;

        // ALU write to r3
        step(1'b1, 16'h0350, 16'h1234, 16'hBEEF, 16'h0300);
        chk("alu_r3", r1Data, 16'h1234);
        chk("alu_r0_unchanged", r0Data, 16'h0000);
        // Mult, op1 = 2
        step(1'b1, 16'h0201, 16'h00AA, 16'h5500, 16'h0220);
        chk("mult_r2", r1Data, 16'h00AA);
        chk("mult_r0", r0Data, 16'h5500);
        // Collision: mult with op1 = 0
        step(1'b1, 16'h0001, 16'h1111, 16'h2222, 16'h0000);
        chk("coll_r0", r0Data, 16'h2222);
        chk("coll_wbEnP", 16'(wbEnP), 16'h0000);
        chk("coll_wbEnS", 16'(wbEnS), 16'h0001);
        // Non-writers
        step(1'b1, 16'hB350, 16'h7777, 16'h7777, 16'h0300);
        step(1'b1, 16'h4350, 16'h7777, 16'h7777, 16'h0300);
        step(1'b0, 16'h0350, 16'h7777, 16'h7777, 16'h0300);
        chk("nonwr_r3", r1Data, 16'h1234);
        chk("nonwr_cnt", retireCount, 16'd5);

        for (int n = 0; n < 300; n++) begin
            fn  = ($urandom_range(0, 2) == 0) ? 4'h1 :
                  ($urandom_range(0, 1) == 0) ? 4'h2 : 4'($urandom);
            ins = {ops[$urandom_range(0, 7)], 4'($urandom), 4'($urandom), fn};
            step($urandom_range(0, 3) != 0, ins, 16'($urandom), 16'($urandom), 16'($urandom));
        end

        // Reset mid-cycle, then hold across an edge with a write presented
        valid5 = 1'b1;
        instructions5 = 16'h0750;
        mux3Out = 16'hA5A5;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            instruction2 = {4'h0, 4'(i), 4'(15 - i), 4'h0};
            #1;
            chk("midreset_r1", r1Data, 16'h0000);
            chk("midreset_r2", r2Data, 16'h0000);
        end
        chk("midreset_r0", r0Data, 16'h0000);
        chk("midreset_cnt", retireCount, 16'h0000);
        chk("midreset_wbEnS", 16'(wbEnS), 16'h0000);
        clear_model();
        @(posedge clk);
        #2;
        instruction2 = 16'h0700;
        #1;
        chk("rst_edge_r7", r1Data, 16'h0000);
        chk("rst_edge_cnt", retireCount, 16'h0000);
        valid5 = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #2;
        step(1'b1, 16'h0750, 16'hA5A5, 16'h0000, 16'h0700);
        chk("after_rst_r7", r1Data, 16'hA5A5);

        // Counter wrap
        valid5 = 1'b1;
        instructions5 = 16'hB000;
        while (mcnt != 16'hFFFF) begin
            @(posedge clk);
            mcnt = mcnt + 16'd1;
        end
        #1 valid5 = 1'b0;
        #1;
        chk("cnt_ffff", retireCount, 16'hFFFF);
        step(1'b1, 16'h0540, 16'hCAFE, 16'h0000, 16'h0500);
        chk("cnt_wrap", retireCount, 16'h0000);
        chk("wrap_r5", r1Data, 16'hCAFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
